// File: rtl/tdm_demux16_pkg.sv
// Shared constants and types for the 16-slot TDM receive path.
package tdm_demux16_pkg;
    localparam int N    = 16;
    localparam int SELW = 4;

    localparam logic [0:SELW-1] SLOT_FIRST = 4'd0;
    localparam logic [0:SELW-1] SLOT_LAST  = 4'd15;

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;
endpackage

// File: rtl/tdm_demux16_if.sv
// Serial-in / frame-out bundle of the TDM demux; master drives the serial side.
interface tdm_demux16_if;
    import tdm_demux16_pkg::*;

    logic            in;
    logic            in_valid;
    logic            frame_start;
    logic [0:SELW-1] sel;
    logic [0:N-1]    out;
    logic            out_valid;
    logic            sync_err;

    modport master (
        output in, in_valid, frame_start,
        input  sel, out, out_valid, sync_err
    );

    modport slave (
        input  in, in_valid, frame_start,
        output sel, out, out_valid, sync_err
    );
endinterface

// File: rtl/tdm_demux16_dec.sv
// 4-to-16 enabled decoder: the structural inverse of the 16-to-1 slot mux.
module dec4to16_en
    import tdm_demux16_pkg::*;
(
    input  logic            en,
    input  logic [0:SELW-1] sel,
    output logic [0:N-1]    onehot
);
    for (genvar k = 0; k < N; k++) begin : g_lane
        assign onehot[k] = en && (sel == SELW'(k));
    end
endmodule

// File: rtl/tdm_demux16.sv
// 16-slot TDM receiver: steers serial bits into a shadow frame and publishes
// complete frames, tracking alignment against the frame-start marker.
module tdm_demux16
    import tdm_demux16_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    tdm_demux16_if.slave   bus
);
    state_t          state;
    logic [0:SELW-1] sel_q;
    logic [0:N-1]    shadow;
    logic [0:N-1]    out_q;
    logic [0:N-1]    we;
    logic            out_valid_q;
    logic            sync_err_q;
    logic            accept;
    logic [0:SELW-1] wr_slot;

    // A marker always restarts the frame at slot 0, whatever sel says.
    assign wr_slot = bus.frame_start ? SLOT_FIRST : sel_q;
    assign accept  = bus.in_valid &&
                     (bus.frame_start || (state == RECV && sel_q != SLOT_FIRST));

    dec4to16_en u_dec (
        .en     (accept),
        .sel    (wr_slot),
        .onehot (we)
    );

    for (genvar k = 0; k < N; k++) begin : g_shadow
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)     shadow[k] <= 1'b0;
            else if (we[k]) shadow[k] <= bus.in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            sel_q       <= SLOT_FIRST;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            if (bus.in_valid) begin
                unique case (state)
                    HUNT: begin
                        if (bus.frame_start) begin
                            sel_q <= SLOT_FIRST + SELW'(1);
                            state <= RECV;
                        end
                    end
                    RECV: begin
                        if (bus.frame_start) begin
                            if (sel_q != SLOT_FIRST) sync_err_q <= 1'b1;
                            sel_q <= SLOT_FIRST + SELW'(1);
                        end else if (sel_q == SLOT_FIRST) begin
                            sync_err_q <= 1'b1;
                            state      <= HUNT;
                        end else if (sel_q == SLOT_LAST) begin
                            // Last bit bypasses the shadow so the frame lands in one edge.
                            out_q       <= {shadow[0:N-2], bus.in};
                            out_valid_q <= 1'b1;
                            sel_q       <= SLOT_FIRST;
                        end else begin
                            sel_q <= sel_q + SELW'(1);
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    assign bus.sel       = sel_q;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sync_err  = sync_err_q;
endmodule

// File: tb/tb_tdm_demux16.sv
// Directed bench for tdm_demux16: expected frames/errors queued at issue time,
// a negedge monitor pops and compares whenever the DUT pulses an output.
module tb_tdm_demux16;
    logic clk = 1'b0;
    logic rst_n;

    tdm_demux16_if bus ();

    tdm_demux16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [0:15] data;
    } exp_t;

    exp_t        sb[$];
    logic [0:15] exp_out = '0;
    int          tests   = 0;
    int          errors  = 0;
    int          cyc     = 0;
    int          last_pulse = 0;
    int          pulse_gap  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (bus.out_valid && bus.sync_err) begin
            tests++; errors++;
            $display("FAIL excl: out_valid and sync_err both high at %0t", $time);
        end
        if (bus.out_valid || bus.sync_err) begin
            if (sb.size() == 0) begin
                tests++; errors++;
                $display("FAIL unexpected: out_valid=%0b sync_err=%0b with empty queue at %0t",
                         bus.out_valid, bus.sync_err, $time);
            end else begin
                e = sb.pop_front();
                chk("kind_err", {31'd0, bus.sync_err}, {31'd0, e.err});
                if (!e.err) begin
                    exp_out    = e.data;
                    pulse_gap  = cyc - last_pulse;
                    last_pulse = cyc;
                end
            end
        end
        chk("out", {16'd0, bus.out}, {16'd0, exp_out});
    end

    task automatic send(input logic b, input logic fs);
        bus.in          = b;
        bus.in_valid    = 1'b1;
        bus.frame_start = fs;
        @(posedge clk); #1;
        bus.in_valid    = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input logic [0:15] w, input bit gaps);
        for (int k = 0; k < 16; k++) begin
            if (k == 15) sb.push_back('{err: 1'b0, data: w});
            send(w[k], k == 0);
            if (gaps && (k == 4 || k == 11)) begin
                for (int g = 0; g < 3; g++) begin
                    idle(1);
                    chk("sel_frozen", {28'd0, bus.sel}, k + 1);
                end
            end
        end
    endtask

    initial begin
        bus.in = 1'b0; bus.in_valid = 1'b0; bus.frame_start = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel",      {28'd0, bus.sel},       0);
        chk("rst_out",      {16'd0, bus.out},       0);
        chk("rst_out_vld",  {31'd0, bus.out_valid}, 0);
        chk("rst_sync_err", {31'd0, bus.sync_err},  0);
        rst_n = 1'b1;
        idle(1);

        // Basic frame, in_valid held high
        send_frame(16'b1010_0000_1111_0001, 1'b0);
        idle(2);

        // Same frame with 3-cycle gaps after slots 4 and 11
        send_frame(16'b1010_0000_1111_0001, 1'b1);
        idle(2);

        // Back-to-back frames
        send_frame(16'hFFFF, 1'b0);
        send_frame(16'h0000, 1'b0);
        idle(1);
        chk("b2b_gap", pulse_gap, 16);

        // Premature marker at sel=7, which starts a clean A5A5 frame
        send(1'b1, 1'b1);
        for (int k = 1; k < 7; k++) send(k[0], 1'b0);
        chk("sel_at_7", {28'd0, bus.sel}, 7);
        sb.push_back('{err: 1'b1, data: 16'h0000});
        send_frame(16'hA5A5, 1'b0);
        idle(2);

        // Unmarked bit at slot 0 drops to HUNT; further unmarked bits are ignored
        sb.push_back('{err: 1'b1, data: 16'h0000});
        send(1'b1, 1'b0);
        idle(1);
        chk("hunt_sel", {28'd0, bus.sel}, 0);
        for (int k = 0; k < 5; k++) send(1'b1, 1'b0);
        chk("hunt_sel_hold", {28'd0, bus.sel}, 0);
        idle(2);

        // Asynchronous reset mid-frame at sel=9
        send(1'b1, 1'b1);
        for (int k = 1; k < 9; k++) send(1'b1, 1'b0);
        chk("sel_at_9", {28'd0, bus.sel}, 9);
        #2;
        rst_n   = 1'b0;
        exp_out = '0;
        #1;
        chk("arst_sel",      {28'd0, bus.sel},       0);
        chk("arst_out",      {16'd0, bus.out},       0);
        chk("arst_out_vld",  {31'd0, bus.out_valid}, 0);
        chk("arst_sync_err", {31'd0, bus.sync_err},  0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        send_frame(16'h3C5A, 1'b0);
        idle(3);

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
